// File: rtl/gyro_pkg.sv
// gyro_pkg: shared constants and helpers for the gyro loop register bank.
// CTRL bit layout and address-map helper.
package gyro_pkg;

  localparam int DW = 32;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_SNAP   = 2;

  typedef struct packed {
    logic wr;
    logic rd;
    logic shd;
    logic ctl;
  } bus_dec_t;

  function automatic int ctrl_addr(input int n_rw, input int n_ro);
    return n_rw + n_ro;
  endfunction

endpackage

// File: rtl/gyro_var_word.sv
// gyro_var_word: one shadow/active parameter word with byte-masked
// write, commit copy and a one-cycle changed-on-commit flag.
module gyro_var_word
  import gyro_pkg::*;
#(
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          commit_i,
  output logic [DW-1:0] shadow_o,
  output logic [DW-1:0] active_o,
  output logic          upd_o,
  output logic          diff_o
);

  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] active_q;
  logic          upd_q;

  always_comb begin
    shadow_d = shadow_q;
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) shadow_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Commit copies the pre-write shadow; a coincident write lands later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
      upd_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) active_q <= shadow_q;
      upd_q <= commit_i & (shadow_q != active_q);
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;
  assign upd_o    = upd_q;
  assign diff_o   = shadow_q != active_q;

endmodule

// File: rtl/gyro_var_bank.sv
// gyro_var_bank: Avalon-MM parameter/status bank for the gyro loop,
// double-buffered parameters and coherent status snapshots.
module gyro_var_bank
  import gyro_pkg::*;
#(
  parameter int          N_RW    = 25,
  parameter int          N_RO    = 25,
  parameter int          AW      = 7,
  parameter logic [31:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [3:0]        byteenable,
  input  logic [DW-1:0]     writedata,
  output logic [DW-1:0]     readdata,
  output logic              readdatavalid,
  output logic [N_RW*DW-1:0] o_reg,
  output logic [N_RW-1:0]   o_upd,
  input  logic [N_RO*DW-1:0] i_var,
  input  logic              i_snap
);

  localparam logic [AW-1:0] CTRL_A = AW'(ctrl_addr(N_RW, N_RO));
  localparam logic [AW-1:0] RW_END = AW'(N_RW);

  bus_dec_t dec;

  logic [DW-1:0]      shadow_w [N_RW];
  logic [N_RW-1:0]    diff_w;
  logic [N_RW-1:0]    we_w;
  logic               commit;
  logic               pending;
  logic               snap_trig;

  logic               auto_q;
  logic               auto_pend_q, auto_pend_d;
  logic [N_RO*DW-1:0] snap_q;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               rvalid_q;

  // A write strobe suppresses a coincident read.
  always_comb begin
    dec.wr  = chipselect & ~write_n;
    dec.rd  = chipselect & ~read_n & write_n;
    dec.shd = address < RW_END;
    dec.ctl = address == CTRL_A;
  end

  assign commit    = (dec.wr & dec.ctl & writedata[CTRL_COMMIT])
                   | auto_pend_q;
  assign snap_trig = i_snap | (dec.wr & dec.ctl & writedata[CTRL_SNAP]);
  assign auto_pend_d = auto_q & dec.wr & dec.shd;
  assign pending   = |diff_w;

  for (genvar k = 0; k < N_RW; k++) begin : g_word
    assign we_w[k] = dec.wr & (address == AW'(k));

    gyro_var_word #(
      .RST_VAL (RST_VAL)
    ) u_word (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (we_w[k]),
      .be_i     (byteenable),
      .wdata_i  (writedata),
      .commit_i (commit),
      .shadow_o (shadow_w[k]),
      .active_o (o_reg[DW*k +: DW]),
      .upd_o    (o_upd[k]),
      .diff_o   (diff_w[k])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (address == AW'(k)) rdata_d = shadow_w[k];
    end
    for (int k = 0; k < N_RO; k++) begin
      if (address == AW'(N_RW + k)) rdata_d = snap_q[DW*k +: DW];
    end
    if (dec.ctl) begin
      rdata_d = '0;
      rdata_d[CTRL_AUTO] = auto_q;
      rdata_d[CTRL_SNAP] = pending;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q      <= 1'b0;
      auto_pend_q <= 1'b0;
      snap_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      auto_pend_q <= auto_pend_d;
      if (dec.wr & dec.ctl) auto_q <= writedata[CTRL_AUTO];
      if (snap_trig) snap_q <= i_var;
      if (dec.rd) rdata_q <= rdata_d;
      rvalid_q <= dec.rd;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule
